// File: rtl/br_predict_redirect_pkg.sv
// Shared widths, encodings and PC-field helpers for the fetch-side branch
// predictor and its redirect handshake.
package br_predict_redirect_pkg;

    localparam int IDX_W   = 4;
    localparam int TAG_W   = 32 - IDX_W - 4;
    localparam int CTR_W   = 2;
    localparam int NUM_ENT = 1 << IDX_W;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FLUSH = 2'b01,
        HOLD  = 2'b10
    } rd_state_e;

    localparam logic [CTR_W-1:0] CTR_INIT = 2'b01;

    function automatic logic [IDX_W-1:0] pc_idx(input logic [31:0] pc);
        return pc[IDX_W+3:4];
    endfunction

    function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
        return pc[31:IDX_W+4];
    endfunction

endpackage

// File: rtl/br_predict_redirect_sat_ctr2.sv
// Next-state function of a 2-bit saturating up/down branch counter.
module sat_ctr2
    import br_predict_redirect_pkg::*;
(
    input  logic [CTR_W-1:0] ctr,
    input  logic             up,
    output logic [CTR_W-1:0] ctr_nxt
);

    // Saturating step toward strongly-taken or strongly-not-taken.
    always_comb begin
        ctr_nxt = ctr;
        if (up) begin
            if (ctr != ST) begin
                ctr_nxt = ctr + 2'd1;
            end else begin
                ctr_nxt = ctr;
            end
        end else begin
            if (ctr != SNT) begin
                ctr_nxt = ctr - 2'd1;
            end else begin
                ctr_nxt = ctr;
            end
        end
    end

endmodule

// File: rtl/br_predict_redirect.sv
// Direct-mapped BTB with 2-bit counters: predicts fetch lines, trains on Ex
// resolutions and drives a held redirect/flush handshake on mispredicts.
module br_predict_redirect
    import br_predict_redirect_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        lk_val,
    input  logic [31:0] lk_pc,
    output logic        pred_val,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        res_val,
    input  logic [31:0] res_pc,
    input  logic        res_taken,
    input  logic        res_correct,
    input  logic [31:0] res_fip,
    input  logic [31:0] res_nextip,
    output logic        redir_val,
    output logic [31:0] redir_ip,
    input  logic        redir_ack,
    output logic        flush
);

    logic [NUM_ENT-1:0] valid_r;
    logic [TAG_W-1:0]   tag_r    [NUM_ENT];
    logic [31:0]        target_r [NUM_ENT];
    logic [CTR_W-1:0]   ctr_r    [NUM_ENT];

    logic [IDX_W-1:0]   lk_idx_s;
    logic               lk_hit_s;
    logic               lk_taken_s;
    logic [IDX_W-1:0]   res_idx_s;
    logic [TAG_W-1:0]   res_tag_s;
    logic               res_hit_s;
    logic [CTR_W-1:0]   ctr_upd_s;

    rd_state_e          state_r;
    rd_state_e          state_nxt_s;
    logic [31:0]        redir_ip_nxt_s;
    logic               mispredict_s;

    // Lookup reads the table as it stands before this edge's update.
    always_comb begin
        lk_idx_s   = pc_idx(lk_pc);
        lk_hit_s   = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == pc_tag(lk_pc));
        lk_taken_s = lk_hit_s && ctr_r[lk_idx_s][1];
    end

    // Resolution-side index/tag match.
    always_comb begin
        res_idx_s = pc_idx(res_pc);
        res_tag_s = pc_tag(res_pc);
        res_hit_s = valid_r[res_idx_s] && (tag_r[res_idx_s] == res_tag_s);
    end

    sat_ctr2 u_sat_ctr2 (
        .ctr     (ctr_r[res_idx_s]),
        .up      (res_taken),
        .ctr_nxt (ctr_upd_s)
    );

    // Valid bits are the only table state that needs a reset.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            valid_r <= '0;
        end else if (res_val && res_taken && !res_hit_s) begin
            valid_r[res_idx_s] <= 1'b1;
        end
    end

    // Training of tag/target/counter; a not-taken miss leaves the entry alone.
    always_ff @(posedge clk) begin
        if (res_val && (res_hit_s || res_taken)) begin
            if (res_hit_s) begin
                ctr_r[res_idx_s] <= ctr_upd_s;
            end else begin
                ctr_r[res_idx_s] <= CTR_INIT + 2'd1;
            end
            if (res_taken) begin
                tag_r[res_idx_s]    <= res_tag_s;
                target_r[res_idx_s] <= res_fip;
            end
        end
    end

    // Registered prediction; lookups are dropped while the flush is in flight.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pred_val    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= 32'h0;
        end else begin
            pred_val    <= lk_val && (state_r != FLUSH);
            pred_taken  <= lk_taken_s;
            pred_target <= lk_taken_s ? target_r[lk_idx_s] : 32'h0;
        end
    end

    // Redirect FSM next state; a mispredict seen during FLUSH is already dead.
    always_comb begin
        state_nxt_s    = state_r;
        redir_ip_nxt_s = redir_ip;
        mispredict_s   = res_val && !res_correct;
        case (state_r)
            IDLE: begin
                if (mispredict_s) begin
                    state_nxt_s    = FLUSH;
                    redir_ip_nxt_s = res_taken ? res_fip : res_nextip;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FLUSH: begin
                if (redir_ack) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            HOLD: begin
                if (mispredict_s) begin
                    state_nxt_s    = FLUSH;
                    redir_ip_nxt_s = res_taken ? res_fip : res_nextip;
                end else if (redir_ack) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register with handshake outputs decoded from the next state.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r   <= IDLE;
            redir_val <= 1'b0;
            redir_ip  <= 32'h0;
            flush     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            redir_val <= (state_nxt_s != IDLE);
            redir_ip  <= redir_ip_nxt_s;
            flush     <= (state_nxt_s == FLUSH);
        end
    end

endmodule
